// File: rtl/syrup_reduce_pkg.sv
// Shared encodings for the Syrup streaming reducer: fold operators,
// controller states and the accumulator start value.
package syrup_reduce_pkg;

  typedef enum logic [1:0] {
    MODE_SUM = 2'd0,
    MODE_XOR = 2'd1,
    MODE_MAX = 2'd2,
    MODE_SAT = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_EMIT  = 2'd3
  } state_e;

  // Every supported operator starts from zero.
  localparam int unsigned IDENTITY_VALUE = 32'd0;

endpackage

// File: rtl/syrup_stream_reducer_if.sv
// Command, memory-read and result signals of the reducer in one bundle.
// The host/memory side uses master; the reducer itself uses slave.
interface syrup_stream_reducer_if #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 32,
  parameter int LEN_WIDTH  = 16
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] stride;
  logic [LEN_WIDTH-1:0]  length;
  logic [1:0]            mode;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_re;
  logic [DATA_WIDTH-1:0] mem_q;
  logic [ACC_WIDTH-1:0]  out_d;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output start, base, stride, length, mode, mem_q, out_ready,
    input  busy, done, mem_addr, mem_re, out_d, out_valid
  );

  modport slave (
    input  start, base, stride, length, mode, mem_q, out_ready,
    output busy, done, mem_addr, mem_re, out_d, out_valid
  );
endinterface

// File: rtl/syrup_valid_pipe.sv
// Delays the read enable by DEPTH cycles so the top bit marks cycles
// where read data is present; o_pending flags reads still in flight.
module syrup_valid_pipe #(
  parameter int DEPTH = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_in,
  output logic o_valid,
  output logic o_pending
);
  logic [DEPTH-1:0] r_pipe;
  logic [DEPTH-1:0] w_upstream;

  // Newest read enters bit 0, oldest leaves at the top bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pipe <= '0;
    end else begin
      r_pipe <= (r_pipe << 1'b1) | DEPTH'(i_in);
    end
  end

  assign w_upstream = r_pipe << 1'b1;
  assign o_valid    = r_pipe[DEPTH-1];
  assign o_pending  = |w_upstream;
endmodule

// File: rtl/syrup_stream_reducer.sv
// Strided memory reduction engine: issues LENGTH reads from BASE by STRIDE,
// folds the returned words with the selected operator, emits on valid/ready.
module syrup_stream_reducer
  import syrup_reduce_pkg::*;
#(
  parameter int ADDR_WIDTH   = 20,
  parameter int DATA_WIDTH   = 32,
  parameter int ACC_WIDTH    = 32,
  parameter int LEN_WIDTH    = 16,
  parameter int READ_LATENCY = 1
) (
  input logic                   i_clk,
  input logic                   i_rst,
  syrup_stream_reducer_if.slave io_bus
);
  state_e                r_state, w_state_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_mem_re, w_mem_re_nxt;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [ADDR_WIDTH-1:0] r_stride, w_stride_nxt;
  logic [LEN_WIDTH-1:0]  r_remain, w_remain_nxt;
  mode_e                 r_mode, w_mode_nxt;
  logic                  r_out_valid, w_out_valid_nxt;
  logic [ACC_WIDTH-1:0]  r_out_d, w_out_d_nxt;
  logic [ACC_WIDTH-1:0]  r_acc, w_acc_nxt;
  logic                  w_vld;
  logic                  w_pending;
  logic [ACC_WIDTH-1:0]  w_q_ext;

  function automatic logic [ACC_WIDTH-1:0] fold(input mode_e m,
                                                input logic [ACC_WIDTH-1:0] acc,
                                                input logic [ACC_WIDTH-1:0] d);
    logic [ACC_WIDTH:0] sum;
    sum = {1'b0, acc} + {1'b0, d};
    case (m)
      MODE_SUM: fold = sum[ACC_WIDTH-1:0];
      MODE_XOR: fold = acc ^ d;
      MODE_MAX: fold = (d > acc) ? d : acc;
      MODE_SAT: fold = sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
      default:  fold = acc;
    endcase
  endfunction

  syrup_valid_pipe #(.DEPTH(READ_LATENCY)) u_valid_pipe (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_in      (r_mem_re),
    .o_valid   (w_vld),
    .o_pending (w_pending)
  );

  assign w_q_ext = ACC_WIDTH'(io_bus.mem_q);

  // Next-state and next-output decode; every register holds by default.
  always_comb begin
    w_state_nxt     = r_state;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    w_mem_re_nxt    = r_mem_re;
    w_mem_addr_nxt  = r_mem_addr;
    w_stride_nxt    = r_stride;
    w_remain_nxt    = r_remain;
    w_mode_nxt      = r_mode;
    w_out_valid_nxt = r_out_valid;
    w_out_d_nxt     = r_out_d;
    w_acc_nxt       = w_vld ? fold(r_mode, r_acc, w_q_ext) : r_acc;
    case (r_state)
      ST_IDLE: begin
        w_busy_nxt = 1'b0;
        // r_busy is still high in the DONE cycle, which blocks a new START there.
        if (io_bus.start && !r_busy) begin
          w_busy_nxt     = 1'b1;
          w_stride_nxt   = io_bus.stride;
          w_mode_nxt     = mode_e'(io_bus.mode);
          w_remain_nxt   = io_bus.length;
          w_acc_nxt      = ACC_WIDTH'(IDENTITY_VALUE);
          w_mem_addr_nxt = io_bus.base;
          if (io_bus.length != LEN_WIDTH'(0)) begin
            w_state_nxt  = ST_ISSUE;
            w_mem_re_nxt = 1'b1;
          end else begin
            w_state_nxt     = ST_EMIT;
            w_out_valid_nxt = 1'b1;
            w_out_d_nxt     = ACC_WIDTH'(IDENTITY_VALUE);
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (r_remain == LEN_WIDTH'(1)) begin
          w_mem_re_nxt = 1'b0;
          w_state_nxt  = ST_DRAIN;
        end else begin
          w_mem_addr_nxt = r_mem_addr + r_stride;
          w_remain_nxt   = r_remain - LEN_WIDTH'(1);
        end
      end
      ST_DRAIN: begin
        if (!w_pending) begin
          w_state_nxt     = ST_EMIT;
          w_out_valid_nxt = 1'b1;
          w_out_d_nxt     = w_acc_nxt;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_EMIT: begin
        if (r_out_valid && io_bus.out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_done_nxt      = 1'b1;
          w_state_nxt     = ST_IDLE;
        end else begin
          w_state_nxt = ST_EMIT;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_addr  <= '0;
      r_stride    <= '0;
      r_remain    <= '0;
      r_mode      <= MODE_SUM;
      r_out_valid <= 1'b0;
      r_out_d     <= '0;
      r_acc       <= '0;
    end else begin
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_mem_re    <= w_mem_re_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_stride    <= w_stride_nxt;
      r_remain    <= w_remain_nxt;
      r_mode      <= w_mode_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_d     <= w_out_d_nxt;
      r_acc       <= w_acc_nxt;
    end
  end

  assign io_bus.busy      = r_busy;
  assign io_bus.done      = r_done;
  assign io_bus.mem_re    = r_mem_re;
  assign io_bus.mem_addr  = r_mem_addr;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_d     = r_out_d;
endmodule

// File: tb/tb_syrup_stream_reducer.sv
// Bench for syrup_stream_reducer: a 32-bit/latency-1 instance (A) and an
// 8-bit/4-bit-address/latency-3 instance (B), driven from a vector table.
module tb_syrup_stream_reducer;
  logic clk;
  logic tb_rst;
  logic cur;
  logic tb_start, tb_ready;
  logic [31:0] tb_base, tb_stride;
  logic [15:0] tb_len;
  logic [1:0]  tb_mode;
  int n_cmp, n_bad;
  logic [31:0] sbq[$];

  syrup_stream_reducer_if #(.ADDR_WIDTH(20), .DATA_WIDTH(32), .ACC_WIDTH(32), .LEN_WIDTH(16)) a_if ();
  syrup_stream_reducer_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .ACC_WIDTH(8), .LEN_WIDTH(16)) b_if ();

  syrup_stream_reducer #(.ADDR_WIDTH(20), .DATA_WIDTH(32), .ACC_WIDTH(32),
                         .LEN_WIDTH(16), .READ_LATENCY(1)) dut_a (
    .i_clk(clk), .i_rst(tb_rst), .io_bus(a_if.slave));
  syrup_stream_reducer #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .ACC_WIDTH(8),
                         .LEN_WIDTH(16), .READ_LATENCY(3)) dut_b (
    .i_clk(clk), .i_rst(tb_rst), .io_bus(b_if.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign a_if.start     = tb_start && !cur;
  assign a_if.base      = tb_base[19:0];
  assign a_if.stride    = tb_stride[19:0];
  assign a_if.length    = tb_len;
  assign a_if.mode      = tb_mode;
  assign a_if.out_ready = cur ? 1'b1 : tb_ready;
  assign b_if.start     = tb_start && cur;
  assign b_if.base      = tb_base[3:0];
  assign b_if.stride    = tb_stride[3:0];
  assign b_if.length    = tb_len;
  assign b_if.mode      = tb_mode;
  assign b_if.out_ready = cur ? tb_ready : 1'b1;

  // Memory models: A returns the address (latency 1), B reads a table (latency 3).
  logic [31:0] qa;
  logic [7:0]  memb [16];
  logic [7:0]  qb1, qb2, qb3;
  always @(posedge clk) begin
    qa  <= a_if.mem_re ? 32'(a_if.mem_addr) : 32'hDEAD_BEEF;
    qb1 <= b_if.mem_re ? memb[b_if.mem_addr] : 8'hEE;
    qb2 <= qb1;
    qb3 <= qb2;
  end
  assign a_if.mem_q = qa;
  assign b_if.mem_q = qb3;

  // View of whichever instance is under test.
  logic        v_re, v_valid, v_busy, v_done;
  logic [31:0] v_addr, v_d;
  assign v_re    = cur ? b_if.mem_re    : a_if.mem_re;
  assign v_valid = cur ? b_if.out_valid : a_if.out_valid;
  assign v_busy  = cur ? b_if.busy      : a_if.busy;
  assign v_done  = cur ? b_if.done      : a_if.done;
  assign v_addr  = cur ? 32'(b_if.mem_addr) : 32'(a_if.mem_addr);
  assign v_d     = cur ? 32'(b_if.out_d)    : a_if.out_d;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst=%0d got=%0d expected=%0d", name, cur, act, exp);
    end
  endtask

  task automatic run(input logic sel, input logic [31:0] base, input logic [31:0] stride,
                     input int len, input logic [1:0] mode, input logic [31:0] exp,
                     input int rdly, input int pulse_at);
    int k, fv, hs, nre, rl;
    logic [31:0] amask, ea, got;
    bit fin;
    rl    = sel ? 3 : 1;
    amask = sel ? 32'hF : 32'hF_FFFF;
    cur = sel; tb_base = base; tb_stride = stride; tb_len = 16'(len); tb_mode = mode;
    tb_ready = 1'b0;
    sbq.push_back(exp);
    tb_start = 1'b1;
    tick();
    tb_start = 1'b0;
    k = 1; fv = -1; hs = -1; nre = 0; fin = 0;
    while (!fin && k < 200) begin
      tb_start = (k == pulse_at);
      if (v_re) begin
        ea = (base + 32'(nre) * stride) & amask;
        chk("re_cycle", 64'(k), 64'(nre + 1));
        chk("mem_addr", 64'(v_addr), 64'(ea));
        nre++;
      end
      if (v_valid && fv < 0) fv = k;
      tb_ready = (fv >= 0) && (k - fv >= rdly);
      if (v_valid && !tb_ready) chk("hold_d", 64'(v_d), 64'(exp));
      if (v_valid && tb_ready) begin
        hs = k;
        if (sbq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL result inst=%0d got=%0d expected=none queued", cur, v_d);
        end else begin
          got = sbq.pop_front();
          chk("result", 64'(v_d), 64'(got));
        end
      end
      if (v_done) begin
        chk("done_lat", 64'(k), 64'(hs + 1));
        chk("done_busy", 64'(v_busy), 64'd1);
        chk("done_valid", 64'(v_valid), 64'd0);
        fin = 1;
      end else begin
        tick();
        k++;
      end
    end
    tb_start = 1'b0;
    if (!fin) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout inst=%0d got=no DONE expected=DONE within 200 cycles", cur);
    end
    chk("re_count", 64'(nre), 64'(len));
    chk("valid_lat", 64'(fv), 64'((len == 0) ? 1 : len + rl + 1));
    tick();
    chk("busy_clear", 64'(v_busy), 64'd0);
    chk("done_pulse", 64'(v_done), 64'd0);
    tb_ready = 1'b1;
  endtask

  typedef struct {
    logic        sel;
    logic [31:0] base;
    logic [31:0] stride;
    int          len;
    logic [1:0]  mode;
    logic [31:0] exp;
    int          rdly;
    int          pulse;
  } vec_t;

  vec_t vecs [9];
  bit   saw_done, saw_valid;

  initial begin
    n_cmp = 0; n_bad = 0;
    cur = 1'b0; tb_rst = 1'b1; tb_start = 1'b0; tb_ready = 1'b1;
    tb_base = 32'd0; tb_stride = 32'd0; tb_len = 16'd0; tb_mode = 2'd0;
    for (int i = 0; i < 16; i++) memb[i] = 8'(i);
    memb[1] = 8'd200; memb[5] = 8'd100; memb[9] = 8'd5;

    vecs[0] = '{1'b0, 32'd0,       32'd4, 4, 2'd0, 32'd24,      0, -1};
    vecs[1] = '{1'b1, 32'd0,       32'd4, 4, 2'd2, 32'd12,      0, -1};
    vecs[2] = '{1'b1, 32'd0,       32'd4, 4, 2'd1, 32'd0,       0, -1};
    vecs[3] = '{1'b1, 32'd1,       32'd4, 3, 2'd3, 32'd255,     0, -1};
    vecs[4] = '{1'b1, 32'd1,       32'd4, 3, 2'd0, 32'd49,      0, -1};
    vecs[5] = '{1'b1, 32'd12,      32'd4, 3, 2'd0, 32'd16,      0,  2};
    vecs[6] = '{1'b0, 32'd0,       32'd0, 0, 2'd0, 32'd0,       5, -1};
    vecs[7] = '{1'b0, 32'd3,       32'd5, 3, 2'd1, 32'd6,       2, -1};
    vecs[8] = '{1'b0, 32'h000F_FFF8, 32'd4, 3, 2'd2, 32'h000F_FFFC, 0, -1};

    repeat (3) tick();
    for (int s = 0; s < 2; s++) begin
      cur = s[0];
      #0;
      chk("rst_busy",  64'(v_busy),  64'd0);
      chk("rst_done",  64'(v_done),  64'd0);
      chk("rst_re",    64'(v_re),    64'd0);
      chk("rst_addr",  64'(v_addr),  64'd0);
      chk("rst_valid", 64'(v_valid), 64'd0);
      chk("rst_d",     64'(v_d),     64'd0);
    end
    tb_rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      run(vecs[i].sel, vecs[i].base, vecs[i].stride, vecs[i].len, vecs[i].mode,
          vecs[i].exp, vecs[i].rdly, vecs[i].pulse);
      repeat (2) tick();
    end

    // Reset in the middle of an 8-element issue burst on instance A.
    cur = 1'b0; tb_base = 32'd0; tb_stride = 32'd4; tb_len = 16'd8; tb_mode = 2'd0;
    tb_start = 1'b1;
    tick();
    tb_start = 1'b0;
    repeat (2) tick();
    chk("mid_re", 64'(v_re), 64'd1);
    tb_rst = 1'b1;
    tick();
    tb_rst = 1'b0;
    chk("rst_mid_busy",  64'(v_busy),  64'd0);
    chk("rst_mid_re",    64'(v_re),    64'd0);
    chk("rst_mid_valid", 64'(v_valid), 64'd0);
    chk("rst_mid_done",  64'(v_done),  64'd0);
    saw_done = 0; saw_valid = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (v_done) saw_done = 1;
      if (v_valid || v_re) saw_valid = 1;
    end
    chk("rst_no_done", 64'(saw_done), 64'd0);
    chk("rst_no_activity", 64'(saw_valid), 64'd0);

    run(1'b0, 32'h100, 32'd8, 5, 2'd0, 32'd1360, 0, -1);
    chk("sb_empty", 64'(sbq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
